imm_decode_ctrl: RTL
====================

// Module: imm_decode_ctrl
// PURPOSE
//  ID-stage immediate controller: accepts fetched instructions over valid/ready, decodes opcode/funct3
//  into the 6-bit EXTOp, drives the EXT1 immediate extender, and registers {imm, ext_op, pc, rd} into a
//  1-deep output stage toward EX. It owns stall (backpressure), flush and illegal-opcode flagging.
// PARAMETERS
//  XLEN     32   datapath width; only 32 is supported
//  PC_W     32   width of the pc sideband carried with each instruction
// PORTS
//  clk        in   1     single clock; all state on rising edge
//  rst        in   1     asynchronous, active-high reset
//  in_valid   in   1     IF presents instr/pc
//  in_ready   out  1     this block accepts when in_valid&&in_ready
//  in_instr   in   32    raw RV32I instruction
//  in_pc      in   PC_W  instruction address
//  flush      in   1     branch/jump redirect from EX: kill all held instructions
//  out_valid  out  1     EX-side entry valid
//  out_ready  in   1     EX accepts when out_valid&&out_ready
//  out_imm    out  32    extended immediate (EXT1 immout, registered)
//  out_extop  out  6     EXTOp used for this instruction
//  out_pc     out  PC_W  pc of this instruction
//  out_rd     out  5     instr[11:7]
//  out_illegal out 1     opcode not in RV32I base set
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-transfer): out_valid=0, out_imm=0, out_extop=0, out_pc=0,
//    out_rd=0, out_illegal=0, state=EMPTY; in_ready reads 1 from the first clk edge after rst drops.
//  - Decode (combinational, opcode=instr[6:0]): 0010011 w/ funct3 001|101 -> ITYPE_SHAMT; other 0010011,
//    0000011, 1100111 -> ITYPE; 0100011 -> STYPE; 1100011 -> BTYPE; 0110111, 0010111 -> UTYPE;
//    1101111 -> JTYPE; 0110011, 0001111, 1110011 -> EXTOp 0 (imm 0), legal; anything else -> EXTOp 0, illegal=1.
//  - EXT1 fields: iimm_shamt=instr[24:20], iimm=instr[31:20], simm={instr[31:25],instr[11:7]},
//    bimm={instr[31],instr[7],instr[30:25],instr[11:8]}, uimm=instr[31:12],
//    jimm={instr[31],instr[19:12],instr[20],instr[30:21]}.
//  - Latency: exactly 1 cycle from input handshake to out_valid with matching fields.
//  - FSM (without skid): EMPTY -> FULL on in handshake; FULL -> EMPTY on out handshake w/o new input;
//    FULL -> FULL on simultaneous out+in handshake (entry replaced). in_ready = !out_valid || out_ready.
//  - Output fields stable while out_valid&&!out_ready; never change except on a load.
//  - flush: next edge forces state EMPTY, out_valid=0; an input handshaked in the same cycle is dropped.
//    flush dominates all simultaneous events; in_ready is not gated by flush.
//  - out_illegal is a per-entry flag, valid only with out_valid; it does not stall.
// CONFIGURATION
//  IMM_DECODE_SKID_EN defined: adds a 1-entry skid register; FSM EMPTY/FULL/SKID; in_ready = (state!=SKID),
//    registered, no combinational path from out_ready. FULL+in handshake+!out_ready -> SKID; SKID+out
//    handshake -> FULL (skid promoted, in order). flush clears both entries. Latency still 1 cycle.
//  Not defined: 2-state FSM above; in_ready combinationally depends on out_ready.
// STRUCTURE
//  - ctrl_encode_def.v (shared): EXT_CTRL_ITYPE_SHAMT..JTYPE codes, RV32I opcode constants
//    (OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, OP, FENCE, SYSTEM), funct3 SLLI/SRxI.
//  - Sub-module imm_op_decode: pure combinational instr -> {extop, illegal}; then instantiate EXT1.
//  - Top holds FSM, payload register(s), flush logic.
// TESTING
//  1 addi x1,x0,-1 0xFFF00093, out_ready=1 -> next cycle out_imm=0xFFFFFFFF, extop=ITYPE, rd=1.
//  2 slli 0x00509093 then sw 0x00112623 back-to-back -> imm 0x00000005 (ITYPE_SHAMT), then 0x0000000C
//    (STYPE); one result per cycle, no bubble.
//  3 beq 0xFE000EE3 with out_ready=0 for 3 cycles -> out_imm=0xFFFFFFFC held stable, in_ready=0
//    (1 with skid until SKID full); release -> lui 0x123450B7 next yields 0x12345000 in order.
//  4 jal 0xFF9FF06F accepted, flush same cycle as next input -> out_valid=0 next cycle, no output for
//    either; following addi accepted normally.
//  5 instr 0x0000007F -> out_illegal=1, extop=0, imm=0; add 0x002081B3 -> illegal=0, imm=0.
//  6 rst asserted mid-stall with out_valid=1 -> all outputs 0 immediately (async), resumes cleanly.

Source files
------------

// File: rtl/imm_decode_ctrl_pkg.sv
// imm_decode_ctrl_pkg: EXTOp codes, RV32I opcode constants, FSM states and payload type
package imm_decode_ctrl_pkg;
  localparam logic [5:0] EXT_CTRL_ITYPE_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_CTRL_ITYPE       = 6'b010000;
  localparam logic [5:0] EXT_CTRL_STYPE       = 6'b001000;
  localparam logic [5:0] EXT_CTRL_BTYPE       = 6'b000100;
  localparam logic [5:0] EXT_CTRL_UTYPE       = 6'b000010;
  localparam logic [5:0] EXT_CTRL_JTYPE       = 6'b000001;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
  typedef struct packed {
    logic [31:0] imm;
    logic [5:0]  extop;
    logic [4:0]  rd;
    logic        illegal;
  } payload_t;
endpackage

// File: rtl/ext1.sv
// ext1: immediate extender selected by one-hot EXTOp
import imm_decode_ctrl_pkg::*;
module ext1 (
  input  logic [4:0]  iimm_shamt,
  input  logic [11:0] iimm,
  input  logic [11:0] simm,
  input  logic [11:0] bimm,
  input  logic [19:0] uimm,
  input  logic [19:0] jimm,
  input  logic [5:0]  extop,
  output logic [31:0] immout
);
  always_comb begin
    immout = extop == EXT_CTRL_ITYPE_SHAMT ? {27'b0, iimm_shamt} :
             extop == EXT_CTRL_ITYPE       ? {{20{iimm[11]}}, iimm} :
             extop == EXT_CTRL_STYPE       ? {{20{simm[11]}}, simm} :
             extop == EXT_CTRL_BTYPE       ? {{19{bimm[11]}}, bimm, 1'b0} :
             extop == EXT_CTRL_UTYPE       ? {uimm, 12'b0} :
             extop == EXT_CTRL_JTYPE       ? {{11{jimm[19]}}, jimm, 1'b0} : 32'b0;
  end
endmodule

// File: rtl/imm_op_decode.sv
// imm_op_decode: combinational opcode/funct3 -> {EXTOp, illegal}
import imm_decode_ctrl_pkg::*;
module imm_op_decode (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic [5:0] extop,
  output logic       illegal
);
  always_comb begin
    extop   = '0;
    illegal = 1'b0;
    case (opcode)
      OP_IMM:             extop = (funct3 == F3_SLLI || funct3 == F3_SRXI) ? EXT_CTRL_ITYPE_SHAMT : EXT_CTRL_ITYPE;
      LOAD, JALR:         extop = EXT_CTRL_ITYPE;
      STORE:              extop = EXT_CTRL_STYPE;
      BRANCH:             extop = EXT_CTRL_BTYPE;
      LUI, AUIPC:         extop = EXT_CTRL_UTYPE;
      JAL:                extop = EXT_CTRL_JTYPE;
      OP, FENCE, SYSTEM:  extop = '0;
      default:            illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl: ID-stage immediate decode with 1-deep output stage, stall and flush.
// Define IMM_DECODE_SKID_EN to add a skid entry and register in_ready.
import imm_decode_ctrl_pkg::*;
module imm_decode_ctrl #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [5:0]      out_extop,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);
  payload_t dec, pay;
  logic [PC_W-1:0] pc_q;
  state_t state, state_n;
  imm_op_decode u_dec (
    .opcode (in_instr[6:0]),
    .funct3 (in_instr[14:12]),
    .extop  (dec.extop),
    .illegal(dec.illegal)
  );
  ext1 u_ext (
    .iimm_shamt(in_instr[24:20]),
    .iimm      (in_instr[31:20]),
    .simm      ({in_instr[31:25], in_instr[11:7]}),
    .bimm      ({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]}),
    .uimm      (in_instr[31:12]),
    .jimm      ({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]}),
    .extop     (dec.extop),
    .immout    (dec.imm)
  );
  assign dec.rd      = in_instr[11:7];
  assign out_valid   = state != EMPTY;
  assign out_imm     = pay.imm;
  assign out_extop   = pay.extop;
  assign out_rd      = pay.rd;
  assign out_illegal = pay.illegal;
  assign out_pc      = pc_q;
`ifdef IMM_DECODE_SKID_EN
  payload_t skid;
  logic [PC_W-1:0] skid_pc;
  logic rdy_q, ld_main, ld_skid, promote;
  logic acc;
  assign in_ready = rdy_q;
  assign acc = in_valid && rdy_q;
  always_comb begin
    state_n = state;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    promote = 1'b0;
    if (!flush)
      case (state)
        EMPTY: begin
          state_n = acc ? FULL : EMPTY;
          ld_main = acc;
        end
        FULL: begin
          state_n = acc ? (out_ready ? FULL : SKID) : (out_ready ? EMPTY : FULL);
          ld_main = acc && out_ready;
          ld_skid = acc && !out_ready;
        end
        default: begin
          state_n = out_ready ? FULL : SKID;
          promote = out_ready;
        end
      endcase
    else
      state_n = EMPTY;
  end
  // in_ready comes from a flop so out_ready never reaches IF combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      rdy_q   <= 1'b0;
      pay     <= '0;
      pc_q    <= '0;
      skid    <= '0;
      skid_pc <= '0;
    end else begin
      state <= state_n;
      rdy_q <= state_n != SKID;
      if (ld_main) begin
        pay  <= dec;
        pc_q <= in_pc;
      end else if (promote) begin
        pay  <= skid;
        pc_q <= skid_pc;
      end
      if (ld_skid) begin
        skid    <= dec;
        skid_pc <= in_pc;
      end
    end
  end
`else
  logic en, load;
  assign in_ready = en && (!out_valid || out_ready);
  assign load = in_valid && in_ready && !flush;
  always_comb begin
    state_n = flush ? EMPTY : load ? FULL : (out_valid && out_ready) ? EMPTY : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      en    <= 1'b0;
      pay   <= '0;
      pc_q  <= '0;
    end else begin
      state <= state_n;
      en    <= 1'b1;
      if (load) begin
        pay  <= dec;
        pc_q <= in_pc;
      end
    end
  end
`endif
endmodule
